// File: rtl/functional_unit_if.sv
// ============================================================================
// Module : functional_unit_if
// Issue-side request and broadcast-side result bundle of the integer unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface functional_unit_if;
   logic        write_enable;
   logic [3:0]  ALUControl;
   logic        ALUSrc;
   logic        is_for_lsq;
   logic [31:0] imm;
   logic [31:0] rs1_value;
   logic [31:0] rs2_value;
   logic [5:0]  tag_to_output;
   logic [5:0]  rob_index;

   logic        is_available;
   logic        wakeup_active;
   logic [5:0]  wakeup_rob_index;
   logic [5:0]  wakeup_tag;
   logic [31:0] wakeup_value;
   logic        lsq_wakeup_active;
   logic [5:0]  lsq_wakeup_rob_index;
   logic [31:0] lsq_wakeup_value;

   modport master (
      output write_enable, ALUControl, ALUSrc, is_for_lsq, imm,
             rs1_value, rs2_value, tag_to_output, rob_index,
      input  is_available, wakeup_active, wakeup_rob_index, wakeup_tag,
             wakeup_value, lsq_wakeup_active, lsq_wakeup_rob_index,
             lsq_wakeup_value
   );

   modport slave (
      input  write_enable, ALUControl, ALUSrc, is_for_lsq, imm,
             rs1_value, rs2_value, tag_to_output, rob_index,
      output is_available, wakeup_active, wakeup_rob_index, wakeup_tag,
             wakeup_value, lsq_wakeup_active, lsq_wakeup_rob_index,
             lsq_wakeup_value
   );
endinterface

`default_nettype wire

// File: rtl/functional_unit.sv
// ============================================================================
// Module : functional_unit
// Single-issue integer ALU with fixed latency and routed wakeup broadcast.
// Optional macro FU_MUL_EN enables the 32-bit low-half multiply (opcode 1100).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module functional_unit #(
   parameter int OP_LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   functional_unit_if.slave bus
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_BUSY   = 1'b1;
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] LAST_CNT = 4'(OP_LATENCY - 1);

   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [5:0]  tag_q;
   logic [5:0]  rob_q;
   logic        lsq_q;

   logic [31:0] b_in;
   logic [31:0] result;
   logic        fire_nop;
   logic        fire_done;
   logic        bc_fire;
   logic        bc_lsq;
   logic [5:0]  bc_tag;
   logic [5:0]  bc_rob;
   logic [31:0] bc_val;

   assign b_in = bus.ALUSrc ? bus.imm : bus.rs2_value;

   // Result is evaluated from the latched operands during the final busy cycle.
   always_comb begin
      result = 32'd0;
      case (op_q)
         4'b0001: result = a_q & b_q;
         4'b0010: result = a_q + b_q;
         4'b0011: result = a_q | b_q;
         4'b0100: result = a_q ^ b_q;
         4'b0101: result = a_q << b_q[4:0];
         4'b0110: result = a_q - b_q;
         4'b0111: result = {31'd0, $signed(a_q) < $signed(b_q)};
         4'b1000: result = {31'd0, a_q < b_q};
         4'b1001: result = a_q >> b_q[4:0];
         4'b1011: result = $unsigned($signed(a_q) >>> b_q[4:0]);
         4'b1111: result = b_q;
`ifdef FU_MUL_EN
         4'b1100: result = a_q * b_q;
`else
         4'b1100: result = 32'd0;
`endif
         default: result = 32'd0;
      endcase
   end

   assign fire_nop  = (state == S_IDLE) && bus.write_enable && (bus.ALUControl == OP_NOP);
   assign fire_done = (state == S_BUSY) && (cnt == LAST_CNT);

   always_comb begin
      bc_fire = fire_nop || fire_done;
      bc_lsq  = lsq_q;
      bc_tag  = tag_q;
      bc_rob  = rob_q;
      bc_val  = result;
      if (fire_nop) begin
         bc_lsq = bus.is_for_lsq;
         bc_tag = bus.tag_to_output;
         bc_rob = bus.rob_index;
         bc_val = 32'd0;
      end
   end

   assign bus.is_available = (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state                    <= S_IDLE;
         cnt                      <= 4'd0;
         op_q                     <= 4'd0;
         a_q                      <= 32'd0;
         b_q                      <= 32'd0;
         tag_q                    <= 6'd0;
         rob_q                    <= 6'd0;
         lsq_q                    <= 1'b0;
         bus.wakeup_active        <= 1'b0;
         bus.wakeup_rob_index     <= 6'd0;
         bus.wakeup_tag           <= 6'd0;
         bus.wakeup_value         <= 32'd0;
         bus.lsq_wakeup_active    <= 1'b0;
         bus.lsq_wakeup_rob_index <= 6'd0;
         bus.lsq_wakeup_value     <= 32'd0;
      end else begin
         bus.wakeup_active     <= 1'b0;
         bus.lsq_wakeup_active <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.write_enable && (bus.ALUControl != OP_NOP)) begin
                  state <= S_BUSY;
                  cnt   <= 4'd1;
                  op_q  <= bus.ALUControl;
                  a_q   <= bus.rs1_value;
                  b_q   <= b_in;
                  tag_q <= bus.tag_to_output;
                  rob_q <= bus.rob_index;
                  lsq_q <= bus.is_for_lsq;
               end
            end
            S_BUSY: begin
               if (cnt == LAST_CNT) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Only the selected bus updates its data; the other keeps its last broadcast.
         if (bc_fire) begin
            if (bc_lsq) begin
               bus.lsq_wakeup_active    <= 1'b1;
               bus.lsq_wakeup_rob_index <= bc_rob;
               bus.lsq_wakeup_value     <= bc_val;
            end else begin
               bus.wakeup_active    <= 1'b1;
               bus.wakeup_tag       <= bc_tag;
               bus.wakeup_rob_index <= bc_rob;
               bus.wakeup_value     <= bc_val;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_functional_unit.sv
// ============================================================================
// Module : tb_functional_unit
// Randomized self-checking bench for functional_unit against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_functional_unit;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [5:0]  exp_tag;
   logic [5:0]  exp_rob;
   logic [31:0] exp_val;
   logic [5:0]  exp_lrob;
   logic [31:0] exp_lval;

   always #5 clk = ~clk;

   functional_unit_if bus();

   functional_unit #(.OP_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'h1: return a & b;
         4'h2: return a + b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return a * (32'd1 << sh);
         4'h6: return a + (~b) + 32'd1;
         4'h7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'h8: return (a < b) ? 32'd1 : 32'd0;
         4'h9: return a / (32'd1 << sh);
         4'hB: return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
         4'hF: return b;
`ifdef FU_MUL_EN
         4'hC: return a * b;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_clear();
      exp_tag  = 6'd0;
      exp_rob  = 6'd0;
      exp_val  = 32'd0;
      exp_lrob = 6'd0;
      exp_lval = 32'd0;
   endtask

   task automatic check_outs(input string ctx, input logic avail, input logic wk, input logic lk);
      check({ctx, ".avail"},  {31'd0, bus.is_available},      {31'd0, avail});
      check({ctx, ".wk_act"}, {31'd0, bus.wakeup_active},     {31'd0, wk});
      check({ctx, ".lq_act"}, {31'd0, bus.lsq_wakeup_active}, {31'd0, lk});
      check({ctx, ".wk_tag"}, {26'd0, bus.wakeup_tag},        {26'd0, exp_tag});
      check({ctx, ".wk_rob"}, {26'd0, bus.wakeup_rob_index},  {26'd0, exp_rob});
      check({ctx, ".wk_val"}, bus.wakeup_value,               exp_val);
      check({ctx, ".lq_rob"}, {26'd0, bus.lsq_wakeup_rob_index}, {26'd0, exp_lrob});
      check({ctx, ".lq_val"}, bus.lsq_wakeup_value,           exp_lval);
   endtask

   task automatic idle_edge(input string ctx);
      @(negedge clk);
      bus.write_enable = 1'b0;
      @(posedge clk);
      #1;
      check_outs(ctx, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drive_junk();
      bus.ALUControl    = 4'($urandom_range(0, 15));
      bus.ALUSrc        = 1'($urandom);
      bus.is_for_lsq    = 1'($urandom);
      bus.imm           = $urandom;
      bus.rs1_value     = $urandom;
      bus.rs2_value     = $urandom;
      bus.tag_to_output = 6'($urandom);
      bus.rob_index     = 6'($urandom);
   endtask

   task automatic do_op(input logic [3:0] op, input logic alusrc, input logic lsq,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [5:0] tag, input logic [5:0] rob, input logic junk);
      logic [31:0] r;
      r = ref_alu(op, rs1, alusrc ? imm : rs2);
      @(negedge clk);
      bus.write_enable  = 1'b1;
      bus.ALUControl    = op;
      bus.ALUSrc        = alusrc;
      bus.is_for_lsq    = lsq;
      bus.imm           = imm;
      bus.rs1_value     = rs1;
      bus.rs2_value     = rs2;
      bus.tag_to_output = tag;
      bus.rob_index     = rob;
      @(posedge clk);
      #1;
      bus.write_enable = 1'b0;
      if (op == 4'h0) begin
         if (lsq) begin exp_lrob = rob; exp_lval = 32'd0; end
         else begin exp_tag = tag; exp_rob = rob; exp_val = 32'd0; end
         check_outs("nop", 1'b1, !lsq, lsq);
      end else begin
         check_outs("busy", 1'b0, 1'b0, 1'b0);
         for (int e = 2; e <= LAT; e++) begin
            if (junk) begin
               drive_junk();
               bus.write_enable = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.write_enable = 1'b0;
            if (e < LAT) begin
               check_outs("busy", 1'b0, 1'b0, 1'b0);
            end else begin
               if (lsq) begin exp_lrob = rob; exp_lval = r; end
               else begin exp_tag = tag; exp_rob = rob; exp_val = r; end
               check_outs("done", 1'b1, !lsq, lsq);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.write_enable = 1'b1;
      drive_junk();
      bus.ALUControl = 4'h2;
      model_clear();

      // Reset with an issue strobe asserted: the write must be ignored.
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b1, 1'b0, 1'b0);
      bus.write_enable = 1'b0;
      reset = 1'b1;
      idle_edge("idle0");

      do_op(4'h0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd2, 1'b0);
      idle_edge("after_nop");
      do_op(4'h0, 1'b0, 1'b1, 32'd0, 32'd7, 32'd9, 6'd5, 6'd7, 1'b0);
      do_op(4'h0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1, 6'd8, 6'd1, 1'b0);
      do_op(4'h2, 1'b0, 1'b0, 32'd0, 32'd2, 32'd3, 6'd4, 6'd3, 1'b0);
      do_op(4'hB, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFB, 32'd0, 6'd0, 6'd6, 1'b0);
      do_op(4'hB, 1'b0, 1'b1, 32'd0, 32'd13, 32'd2, 6'd0, 6'd2, 1'b0);
      do_op(4'hF, 1'b1, 1'b0, 32'd456, 32'd0, 32'd0, 6'd3, 6'd9, 1'b0);
      do_op(4'h7, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd1, 6'd10, 6'd11, 1'b1);
      do_op(4'h8, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd1, 6'd12, 6'd13, 1'b1);
      do_op(4'h6, 1'b0, 1'b1, 32'd0, 32'd0, 32'd1, 6'd14, 6'd15, 1'b0);
      do_op(4'hC, 1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 6'd16, 6'd17, 1'b0);
      do_op(4'hA, 1'b0, 1'b0, 32'd0, 32'd5, 32'd5, 6'd18, 6'd19, 1'b0);
      idle_edge("idle1");

      // Abort an in-flight ADD with reset.
      @(negedge clk);
      bus.write_enable  = 1'b1;
      bus.ALUControl    = 4'h2;
      bus.ALUSrc        = 1'b0;
      bus.is_for_lsq    = 1'b0;
      bus.rs1_value     = 32'd10;
      bus.rs2_value     = 32'd20;
      bus.tag_to_output = 6'd21;
      bus.rob_index     = 6'd22;
      @(posedge clk);
      #1;
      bus.write_enable = 1'b0;
      check_outs("abort_busy", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      model_clear();
      check_outs("abort_rst", 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i <= LAT; i++) idle_edge("post_abort");

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
         do_op(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), $urandom, a, b,
               6'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0) idle_edge("rand_idle");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
